// File: rtl/output_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : output_scheduler_pkg
//  Description : Shared constants for the output scheduler and switch fabric:
//                one-hot requester selects, scheduler state encodings,
//                default downstream credit depth and a one-hot decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package output_scheduler_pkg;

    // One-hot requester selects, same order as the crossbar mux inputs
    localparam logic [3:0] c_rqs0 = 4'b0001;
    localparam logic [3:0] c_rqs1 = 4'b0010;
    localparam logic [3:0] c_rqs2 = 4'b0100;
    localparam logic [3:0] c_rqs3 = 4'b1000;

    // Scheduler state encodings
    localparam logic [0:0] c_state_idle   = 1'b0;
    localparam logic [0:0] c_state_active = 1'b1;

    // Default downstream input-buffer depth in flits
    localparam int c_default_credits = 4;

    // Index of the set bit in a one-hot (or zero) 4-bit vector
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx[0] = oh[1] | oh[3];
        idx[1] = oh[2] | oh[3];
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_scheduler_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_4
//  Description : Combinational 4-way round-robin pick. Searches the request
//                vector from the pointer upward, wrapping 3->0, and returns
//                a one-hot grant (zero when nothing is requested).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant
);

    logic [1:0] w_idx;
    logic       w_found;

    // First requester at or above the pointer wins, wrapping around
    always_comb begin
        grant   = '0;
        w_idx   = ptr;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_idx = ptr + 2'(i);
            if (req[w_idx] && !w_found) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : output_scheduler
//  Description : Per-output-port wormhole scheduler. Round-robin arbitration
//                among four input queues, packet lock until the tail flit,
//                pop strobes gated by downstream credits, and a flit-valid
//                aligned with the crossbar output register.
//                Optional statistics counters: OUTPUT_SCHEDULER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_scheduler
    import output_scheduler_pkg::*;
#(
    parameter int CREDITS      = c_default_credits,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              rqs_din,
    input  logic [3:0]              flit_valid_din,
    input  logic [3:0]              tail_din,
    input  logic                    credit_in_din,
    output logic [3:0]              conf_dout,
    output logic [3:0]              pop_dout,
    output logic                    valid_dout,
    output logic [CREDIT_WIDTH-1:0] credits_dout
`ifdef OUTPUT_SCHEDULER_STATS_EN
    ,
    output logic [15:0]             packet_count_dout,
    output logic [15:0]             stall_count_dout
`endif
);

    localparam logic [CREDIT_WIDTH-1:0] c_credits_max = CREDIT_WIDTH'(CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] c_credit_one  = CREDIT_WIDTH'(1);

    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    logic [3:0]              r_conf;
    logic [1:0]              r_ptr;
    logic [CREDIT_WIDTH-1:0] r_credits;
    logic                    r_valid;

    logic [3:0]              w_grant;
    logic [1:0]              w_sel;
    logic                    w_active;
    logic                    w_head_valid;
    logic                    w_head_tail;
    logic                    w_has_credit;
    logic                    w_xfer;
    logic                    w_release;

    // The held one-hot select doubles as the mux for the winner's flags
    assign w_sel        = onehot_to_idx(r_conf);
    assign w_active     = (r_state == c_state_active);
    assign w_head_valid = |(r_conf & flit_valid_din);
    assign w_head_tail  = |(r_conf & tail_din);
    assign w_has_credit = (r_credits != '0);
    assign w_xfer       = w_active & w_head_valid & w_has_credit;
    assign w_release    = w_xfer & w_head_tail;

    assign conf_dout    = r_conf;
    assign valid_dout   = r_valid;
    assign credits_dout = r_credits;

    rr_arbiter_4 u_rr_arbiter_4 (
        .req   (rqs_din),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_state_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: lock on any request, release only on a transferred tail
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_state_idle:   if (|rqs_din)  w_state_next = c_state_active;
            c_state_active: if (w_release) w_state_next = c_state_idle;
            default:                       w_state_next = c_state_idle;
        endcase
    end

    // Outputs: pop the locked queue in the same cycle a flit moves
    always_comb begin
        pop_dout = r_conf & {4{w_xfer}};
    end

    // Crossbar select and round-robin pointer; the pointer moves past the
    // winner only once its packet has fully left
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conf <= '0;
            r_ptr  <= '0;
        end else if (!w_active && (|rqs_din)) begin
            r_conf <= w_grant;
        end else if (w_release) begin
            r_conf <= '0;
            r_ptr  <= w_sel + 2'd1;
        end
    end

    // Credit counter and flit-valid aligned with the crossbar output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credits <= c_credits_max;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_xfer;
            case ({w_xfer, credit_in_din})
                2'b10:   r_credits <= r_credits - c_credit_one;
                2'b01:   if (r_credits != c_credits_max) r_credits <= r_credits + c_credit_one;
                default: r_credits <= r_credits;
            endcase
        end
    end

`ifdef OUTPUT_SCHEDULER_STATS_EN
    logic [15:0] r_packet_count;
    logic [15:0] r_stall_count;
    logic        w_stall;

    assign w_stall           = w_active & w_head_valid & ~w_has_credit;
    assign packet_count_dout = r_packet_count;
    assign stall_count_dout  = r_stall_count;

    // Packet counter wraps; stall counter saturates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_packet_count <= '0;
            r_stall_count  <= '0;
        end else begin
            if (w_release) r_packet_count <= r_packet_count + 16'd1;
            if (w_stall && (r_stall_count != 16'hFFFF)) r_stall_count <= r_stall_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_scheduler
//  Description : Self-checking bench for output_scheduler: directed vector
//                table, hand-written corner sequences and randomized traffic
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_scheduler;

    localparam int CREDITS = 4;

    logic       clk;
    logic       reset;
    logic [3:0] rqs_din;
    logic [3:0] flit_valid_din;
    logic [3:0] tail_din;
    logic       credit_in_din;
    logic [3:0] conf_dout;
    logic [3:0] pop_dout;
    logic       valid_dout;
    logic [2:0] credits_dout;
`ifdef OUTPUT_SCHEDULER_STATS_EN
    logic [15:0] packet_count_dout;
    logic [15:0] stall_count_dout;
`endif

    output_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .rqs_din        (rqs_din),
        .flit_valid_din (flit_valid_din),
        .tail_din       (tail_din),
        .credit_in_din  (credit_in_din),
        .conf_dout      (conf_dout),
        .pop_dout       (pop_dout),
        .valid_dout     (valid_dout),
        .credits_dout   (credits_dout)
`ifdef OUTPUT_SCHEDULER_STATS_EN
        ,
        .packet_count_dout (packet_count_dout),
        .stall_count_dout  (stall_count_dout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int g_tests = 0;
    int g_fails = 0;
    int g_cyc   = 0;

    // Reference model state (plain integers, packet-level view)
    bit m_busy;
    int m_sel;
    int m_ptr;
    int m_credits;
    bit m_valid;
    int m_pkts;
    int m_stalls;

    typedef struct {
        logic [3:0] rqs;
        logic [3:0] fv;
        logic [3:0] tl;
        logic       cin;
        logic [3:0] conf;
        logic [3:0] pop;
        logic       valid;
        logic [2:0] cred;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        g_tests++;
        if (got !== exp) begin
            g_fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, g_cyc, got, exp);
        end
    endtask

    function automatic bit model_xfer();
        return m_busy && flit_valid_din[m_sel] && (m_credits > 0);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_ptr = 0; m_credits = CREDITS;
        m_valid = 0; m_pkts = 0; m_stalls = 0;
    endtask

    task automatic model_check();
        logic [3:0] e_conf;
        logic [3:0] e_pop;
        e_conf = m_busy ? 4'(1 << m_sel) : 4'b0000;
        e_pop  = model_xfer() ? e_conf : 4'b0000;
        check("conf", 16'(conf_dout), 16'(e_conf));
        check("pop", 16'(pop_dout), 16'(e_pop));
        check("valid", 16'(valid_dout), 16'(m_valid));
        check("credits", 16'(credits_dout), 16'(m_credits));
`ifdef OUTPUT_SCHEDULER_STATS_EN
        check("packet_count", packet_count_dout, 16'(m_pkts));
        check("stall_count", stall_count_dout, 16'(m_stalls));
`endif
    endtask

    task automatic model_step();
        bit x;
        bit found;
        x = model_xfer();
        if (m_busy && flit_valid_din[m_sel] && m_credits == 0 && m_stalls < 65535) m_stalls++;
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (rqs_din[j] && !found) begin
                    found = 1; m_sel = j; m_busy = 1;
                end
            end
        end else if (x && tail_din[m_sel]) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % 4;
            m_pkts = (m_pkts + 1) % 65536;
        end
        m_credits = m_credits - int'(x) + int'(credit_in_din);
        if (m_credits > CREDITS) m_credits = CREDITS;
        m_valid = x;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model
    task automatic cycle(input logic [3:0] rqs, input logic [3:0] fv,
                         input logic [3:0] tl, input logic cin);
        @(negedge clk);
        rqs_din = rqs; flit_valid_din = fv; tail_din = tl; credit_in_din = cin;
        g_cyc++;
        #1;
        model_check();
        model_step();
    endtask

    // Asynchronous reset asserted away from any clock edge; inputs left as-is
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_conf", 16'(conf_dout), 16'h0);
        check("rst_pop", 16'(pop_dout), 16'h0);
        check("rst_valid", 16'(valid_dout), 16'h0);
        check("rst_credits", 16'(credits_dout), 16'(CREDITS));
`ifdef OUTPUT_SCHEDULER_STATS_EN
        check("rst_pkts", packet_count_dout, 16'h0);
        check("rst_stalls", stall_count_dout, 16'h0);
`endif
        model_reset();
        rqs_din = '0; flit_valid_din = '0; tail_din = '0; credit_in_din = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] order [$];
        logic [3:0] exp_order [5];
        int         pops;

        // rqs, fv, tail, cin | conf, pop, valid, credits
        tbl[0] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd4};
        tbl[1] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b0, 3'd4};
        tbl[2] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 3'd3};
        tbl[3] = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 3'd2};
        tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 3'd1};
        tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd1};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd2};
        tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd3};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd4};
        tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd4};
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        reset = 1'b1;
        rqs_din = '0; flit_valid_din = '0; tail_din = '0; credit_in_din = 1'b0;
        model_reset();
        do_reset();

        // 3-flit packet from RQS2, then credit returns up to saturation
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].rqs, tbl[i].fv, tbl[i].tl, tbl[i].cin);
            check("tbl_conf", 16'(conf_dout), 16'(tbl[i].conf));
            check("tbl_pop", 16'(pop_dout), 16'(tbl[i].pop));
            check("tbl_valid", 16'(valid_dout), 16'(tbl[i].valid));
            check("tbl_credits", 16'(credits_dout), 16'(tbl[i].cred));
        end

        // All requesters, single-flit packets: grants rotate and wrap
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(4'b1111, 4'b1111, 4'b1111, 1'b1);
            if (pop_dout != 4'b0000) order.push_back(pop_dout);
        end
        check("rr_count", 16'(order.size() >= 5), 16'h1);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) check("rr_order", 16'(order[i]), 16'(exp_order[i]));
        end

        // Credit exhaustion: 4 pops, stall with conf held, one credit -> one pop
        do_reset();
        pops = 0;
        cycle(4'b0010, 4'b0010, 4'b0000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle(4'b0000, 4'b0010, 4'b0000, 1'b0);
            if (pop_dout != 4'b0000) pops++;
        end
        check("stall_pops", 16'(pops), 16'd4);
        check("stall_conf", 16'(conf_dout), 16'(4'b0010));
        check("stall_valid", 16'(valid_dout), 16'h0);
        cycle(4'b0000, 4'b0010, 4'b0000, 1'b1);
        check("credit_cycle_pop", 16'(pop_dout), 16'h0);
        cycle(4'b0000, 4'b0010, 4'b0000, 1'b0);
        check("resume_pop", 16'(pop_dout), 16'(4'b0010));
        cycle(4'b0000, 4'b0010, 4'b0000, 1'b0);
        check("restall_pop", 16'(pop_dout), 16'h0);
        check("resume_valid", 16'(valid_dout), 16'h1);

        // Credit return coincident with a transfer at credits=2
        do_reset();
        cycle(4'b1000, 4'b1000, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b1000, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b1000, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b1000, 4'b0000, 1'b1);
        check("coinc_pop", 16'(pop_dout), 16'(4'b1000));
        cycle(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("coinc_credits", 16'(credits_dout), 16'd2);

        // Reset in the middle of a 5-flit packet, then fresh arbitration
        do_reset();
        cycle(4'b0010, 4'b0010, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0010, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0010, 4'b0000, 1'b0);
        do_reset();
        cycle(4'b0011, 4'b0011, 4'b0000, 1'b0);
        cycle(4'b0011, 4'b0011, 4'b0000, 1'b0);
        check("post_reset_grant", 16'(conf_dout), 16'(4'b0001));

`ifdef OUTPUT_SCHEDULER_STATS_EN
        // Three packets, the second one stalls for two cycles
        do_reset();
        cycle(4'b0001, 4'b0001, 4'b0001, 1'b0);
        cycle(4'b0000, 4'b0001, 4'b0001, 1'b0);
        cycle(4'b0010, 4'b0010, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0010, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0010, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0010, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0010, 4'b0010, 1'b0);
        cycle(4'b0000, 4'b0010, 4'b0010, 1'b1);
        cycle(4'b0000, 4'b0010, 4'b0010, 1'b0);
        cycle(4'b0100, 4'b0100, 4'b0100, 1'b1);
        cycle(4'b0000, 4'b0100, 4'b0100, 1'b0);
        cycle(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("stats_pkts", packet_count_dout, 16'd3);
        check("stats_stalls", stall_count_dout, 16'd2);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] r;
            logic [3:0] f;
            logic [3:0] t;
            r = 4'($urandom_range(0, 15));
            f = r | 4'($urandom_range(0, 15));
            t = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            cycle(r, f, t, ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", g_tests, g_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/output_scheduler.md
Name: output_scheduler

Overview:
- Per-output-port control block that drives one `conf_*_din` select of `switch_fabric`; one instance per output port (pe, x+, y+, x-, y-).
- Arbitrates among the four opposite input ports with round-robin priority.
- Locks the winner for a whole packet (wormhole), issues pop strobes to the winning input queue and gates transfers on downstream credits.
- Produces a flit-valid aligned with the crossbar's registered output.

Parameters:
CREDITS, 4, downstream input-buffer depth in flits (reset value of credit counter)
CREDIT_WIDTH, 3, credit counter width; must hold 0..CREDITS

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rqs_din  input  4  one-hot-per-requester request; bit i = input queue i holds a head flit routed to this output (RQS0..RQS3 order, same as crossbar mux order)
flit_valid_din  input  4  bit i = input queue i non-empty
tail_din  input  4  bit i = head flit of queue i is a tail flit
credit_in_din  input  1  one-cycle pulse per slot freed in downstream buffer
conf_dout  output  4  one-hot crossbar select; 4'b0000 when idle
pop_dout  output  4  one-hot read strobe to winning input queue, one cycle per flit transferred
valid_dout  output  1  downstream flit-valid, aligned with crossbar output register
credits_dout  output  CREDIT_WIDTH  current credit count

Behaviour:
- Reset (asynchronous on reset low, any time including mid-packet):
  - state IDLE, conf_dout=0, pop_dout=0, valid_dout=0.
  - credits=CREDITS, RR pointer=0 (RQS0 highest priority).
- FSM IDLE:
  - If rqs_din!=0, select the first set bit searching from the pointer upward, wrapping 3->0.
  - Register one-hot conf_dout; go ACTIVE. Arbitration latency: 1 cycle.
  - No pop in IDLE.
- FSM ACTIVE:
  - rqs_din ignored; conf_dout held.
  - xfer = flit_valid_din[sel] & (credits!=0).
  - pop_dout = conf_dout & {4{xfer}}, combinational in the same cycle.
  - On xfer & tail_din[sel]:
    - next state IDLE; conf_dout=0 next cycle.
    - pointer = sel+1 mod 4.
  - A request dropped before the tail does not release the lock.
- Single-flit packet (head is tail): IDLE -> ACTIVE -> one pop -> IDLE. Minimum 2 cycles per packet, no back-to-back same-cycle re-arbitration.
- valid_dout: registered copy of xfer, asserted the cycle after the pop, matching the crossbar output register.
- Credits:
  - Decrement on xfer; increment on credit_in_din; both in the same cycle leaves the count unchanged.
  - Increment at CREDITS saturates.
  - Decrement at 0 is impossible (xfer gated).
- Credits=0 while ACTIVE: stall, conf held, no pop, valid_dout=0. Resume on the first credit return: xfer in the cycle after the credit arrives.

Optional Feature:
- Macro OUTPUT_SCHEDULER_STATS_EN.
- Defined:
  - Extra output packet_count_dout [15:0]; increments on every tail transfer and wraps 16'hFFFF->0.
  - Extra output stall_count_dout [15:0]; increments each ACTIVE cycle with flit_valid_din[sel] & credits==0, saturating at 16'hFFFF.
  - Both reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- system.vh holds:
  - RQS0..RQS3 one-hot constants, shared with `switch_fabric`.
  - State encodings IDLE/ACTIVE.
  - Default CREDITS.
- One natural sub-module: rr_arbiter_4, combinational 4-way round-robin pick from request vector plus pointer, one-hot out. Pointer register stays in output_scheduler.

Test Plan:
- Reset, then rqs_din=4'b0100, flit_valid=4'b0100, 3-flit packet (tail on 3rd) -> conf_dout=4'b0100 one cycle later; pop_dout=4'b0100 three consecutive cycles; valid_dout lags pop by 1; conf_dout=0 after tail; credits 4->1.
- rqs_din=4'b1111 held, single-flit packets -> grant order RQS0,RQS1,RQS2,RQS3,RQS0; pointer wraps.
- CREDITS=4, 6-flit packet, no credit returns -> 4 pops then stall with conf held. Single credit_in pulse -> exactly one more pop next cycle.
- credit_in_din coincident with xfer at credits=2 -> credits stays 2. credit_in_din at credits=4 -> stays 4.
- reset low mid-packet (after 2 of 5 flits) -> conf_dout, pop_dout, valid_dout = 0 immediately; credits=4; after release, rqs_din=4'b0011 grants RQS0.
- With OUTPUT_SCHEDULER_STATS_EN: 3 packets, one with 2 stall cycles -> packet_count_dout=3, stall_count_dout=2.
